// File: rtl/capture_ram_writer.sv
// capture_ram_writer: triggered sample-capture controller driving port A (write side) of a capture RAM.
// Ports:
//   CLK, RST           clock; asynchronous active-high reset
//   ARM, ABORT         start a capture from IDLE/DONE; return to IDLE from any state
//   SAMPLE_DI/VLD      sample data and strobe
//   TRIG               trigger, qualified by SAMPLE_VLD
//   POST_CNT           post-trigger sample count, sampled at the trigger
//   RAM_DI/ADDR/WE     registered write port to the RAM
//   BUSY, TRIGGERED, DONE, WRAPPED, TRIG_ADDR, LAST_ADDR  capture status for the host
module capture_ram_writer #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  ARM,
   input  logic                  ABORT,
   input  logic [DATA_WIDTH-1:0] SAMPLE_DI,
   input  logic                  SAMPLE_VLD,
   input  logic                  TRIG,
   input  logic [ADDR_WIDTH-1:0] POST_CNT,
   output logic [DATA_WIDTH-1:0] RAM_DI,
   output logic [ADDR_WIDTH-1:0] RAM_ADDR,
   output logic                  RAM_WE,
   output logic                  BUSY,
   output logic                  TRIGGERED,
   output logic                  DONE,
   output logic                  WRAPPED,
   output logic [ADDR_WIDTH-1:0] TRIG_ADDR,
   output logic [ADDR_WIDTH-1:0] LAST_ADDR
);
   typedef enum logic [1:0] {S_IDLE, S_PRE, S_POST, S_DONE} state_t;
   state_t state, state_n;
   logic [ADDR_WIDTH-1:0] wp, wp_n, rem, rem_n, addr_n, trig_addr_n, last_addr_n;
   logic [DATA_WIDTH-1:0] di_n;
   logic we_n, trig_n, wrap_n, busy_n, done_n;
   logic writing;
   assign writing = SAMPLE_VLD && (state == S_PRE || state == S_POST);
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state     <= S_IDLE;
         wp        <= '0;
         rem       <= '0;
         RAM_DI    <= '0;
         RAM_ADDR  <= '0;
         RAM_WE    <= 1'b0;
         BUSY      <= 1'b0;
         TRIGGERED <= 1'b0;
         DONE      <= 1'b0;
         WRAPPED   <= 1'b0;
         TRIG_ADDR <= '0;
         LAST_ADDR <= '0;
      end else begin
         state     <= state_n;
         wp        <= wp_n;
         rem       <= rem_n;
         RAM_DI    <= di_n;
         RAM_ADDR  <= addr_n;
         RAM_WE    <= we_n;
         BUSY      <= busy_n;
         TRIGGERED <= trig_n;
         DONE      <= done_n;
         WRAPPED   <= wrap_n;
         TRIG_ADDR <= trig_addr_n;
         LAST_ADDR <= last_addr_n;
      end
   end
   always_comb begin
      state_n     = state;
      wp_n        = wp;
      rem_n       = rem;
      di_n        = RAM_DI;
      addr_n      = RAM_ADDR;
      we_n        = 1'b0;
      trig_n      = TRIGGERED;
      wrap_n      = WRAPPED;
      trig_addr_n = TRIG_ADDR;
      last_addr_n = LAST_ADDR;
      if (ABORT) begin
         // record addresses and WRAPPED survive an abort so the host can still inspect them
         state_n = S_IDLE;
         trig_n  = 1'b0;
      end else if (ARM && (state == S_IDLE || state == S_DONE)) begin
         state_n     = S_PRE;
         wp_n        = '0;
         trig_n      = 1'b0;
         wrap_n      = 1'b0;
         trig_addr_n = '0;
         last_addr_n = '0;
      end else if (writing) begin
         we_n   = 1'b1;
         addr_n = wp;
         di_n   = SAMPLE_DI;
         wp_n   = wp + 1'b1;
         if (state == S_PRE) begin
            // any pre-trigger write leaving the top address means older samples are being overwritten
            wrap_n = WRAPPED | (&wp);
            if (TRIG) begin
               trig_n      = 1'b1;
               trig_addr_n = wp;
               rem_n       = POST_CNT;
               state_n     = (POST_CNT == '0) ? S_DONE : S_POST;
               last_addr_n = (POST_CNT == '0) ? wp : LAST_ADDR;
            end
         end else begin
            rem_n       = rem - 1'b1;
            state_n     = (rem == ADDR_WIDTH'(1)) ? S_DONE : S_POST;
            last_addr_n = (rem == ADDR_WIDTH'(1)) ? wp : LAST_ADDR;
         end
      end
      busy_n = (state_n == S_PRE) || (state_n == S_POST);
      done_n = (state_n == S_DONE);
   end
endmodule

// File: tb/tb_capture_ram_writer.sv
// tb_capture_ram_writer: scoreboard bench for capture_ram_writer with a 16-entry buffer.
module tb_capture_ram_writer;
   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       ARM = 1'b0;
   logic       ABORT = 1'b0;
   logic [7:0] SAMPLE_DI = '0;
   logic       SAMPLE_VLD = 1'b0;
   logic       TRIG = 1'b0;
   logic [3:0] POST_CNT = '0;
   logic [7:0] RAM_DI;
   logic [3:0] RAM_ADDR;
   logic       RAM_WE;
   logic       BUSY;
   logic       TRIGGERED;
   logic       DONE;
   logic       WRAPPED;
   logic [3:0] TRIG_ADDR;
   logic [3:0] LAST_ADDR;

   capture_ram_writer #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
      .CLK(CLK), .RST(RST), .ARM(ARM), .ABORT(ABORT),
      .SAMPLE_DI(SAMPLE_DI), .SAMPLE_VLD(SAMPLE_VLD), .TRIG(TRIG), .POST_CNT(POST_CNT),
      .RAM_DI(RAM_DI), .RAM_ADDR(RAM_ADDR), .RAM_WE(RAM_WE),
      .BUSY(BUSY), .TRIGGERED(TRIGGERED), .DONE(DONE), .WRAPPED(WRAPPED),
      .TRIG_ADDR(TRIG_ADDR), .LAST_ADDR(LAST_ADDR)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [3:0] a;
      logic [7:0] d;
      int         c;
   } wr_t;

   wr_t        sbq[$];
   logic [7:0] mem [16];
   int         cyc = 0;
   int         wcnt = 0;
   int         checks = 0;
   int         errors = 0;

   always @(posedge CLK) cyc++;

   always @(negedge CLK) begin
      if (RAM_WE) begin
         wr_t e;
         checks++;
         if (sbq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: got addr %0d data %h cycle %0d, required no write", RAM_ADDR, RAM_DI, cyc);
         end else begin
            e = sbq.pop_front();
            if (RAM_ADDR !== e.a || RAM_DI !== e.d || cyc !== e.c) begin
               errors++;
               $display("FAIL ram_write: got addr %0d data %h cycle %0d, required addr %0d data %h cycle %0d",
                        RAM_ADDR, RAM_DI, cyc, e.a, e.d, e.c);
            end
         end
         mem[RAM_ADDR] = RAM_DI;
         wcnt++;
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic arm();
      ARM = 1'b1;
      idle(1);
      ARM = 1'b0;
   endtask

   task automatic smp(input logic [7:0] d, input logic t, input bit wr, input logic [3:0] a);
      SAMPLE_DI = d;
      TRIG = t;
      SAMPLE_VLD = 1'b1;
      if (wr) sbq.push_back('{a, d, cyc + 1});
      idle(1);
      SAMPLE_VLD = 1'b0;
      TRIG = 1'b0;
   endtask

   task automatic drain(input string name);
      idle(2);
      checks++;
      if (sbq.size() != 0) begin
         errors++;
         $display("FAIL %s_pending_writes: got %0d outstanding, required 0", name, sbq.size());
         sbq.delete();
      end
   endtask

   task automatic test_reset();
      idle(2);
      checks++;
      if ({RAM_DI, RAM_ADDR, RAM_WE, BUSY, TRIGGERED, DONE, WRAPPED, TRIG_ADDR, LAST_ADDR} !== 28'd0) begin
         errors++;
         $display("FAIL reset_outputs: got %h, required 0",
                  {RAM_DI, RAM_ADDR, RAM_WE, BUSY, TRIGGERED, DONE, WRAPPED, TRIG_ADDR, LAST_ADDR});
      end
      RST = 1'b0;
      smp(8'hEE, 1'b0, 0, 4'd0);
      drain("idle_ignore");
   endtask

   task automatic test_basic();
      wcnt = 0;
      arm();
      checks++;
      if (BUSY !== 1'b1) begin errors++; $display("FAIL basic_busy_after_arm: got %b, required 1", BUSY); end
      POST_CNT = 4'd3;
      for (int i = 0; i < 5; i++) smp(8'h10 + 8'(i), i == 4, 1, 4'(i));
      checks++;
      if (TRIGGERED !== 1'b1) begin errors++; $display("FAIL basic_triggered: got %b, required 1", TRIGGERED); end
      for (int i = 5; i < 8; i++) smp(8'h10 + 8'(i), 1'b0, 1, 4'(i));
      checks++;
      if ({DONE, BUSY, WRAPPED, TRIG_ADDR, LAST_ADDR} !== {3'b100, 4'd4, 4'd7}) begin
         errors++;
         $display("FAIL basic_status: got done %b busy %b wrapped %b trig %0d last %0d, required 1 0 0 4 7",
                  DONE, BUSY, WRAPPED, TRIG_ADDR, LAST_ADDR);
      end
      drain("basic");
      checks++;
      if (wcnt !== 8) begin errors++; $display("FAIL basic_write_count: got %0d, required 8", wcnt); end
   endtask

   task automatic test_wrap();
      arm();
      POST_CNT = 4'd2;
      for (int i = 0; i < 21; i++) smp(8'h20 + 8'(i), i == 20, 1, 4'(i));
      for (int i = 21; i < 23; i++) smp(8'h20 + 8'(i), 1'b0, 1, 4'(i));
      checks++;
      if ({DONE, WRAPPED, TRIG_ADDR, LAST_ADDR} !== {2'b11, 4'd4, 4'd6}) begin
         errors++;
         $display("FAIL wrap_status: got done %b wrapped %b trig %0d last %0d, required 1 1 4 6",
                  DONE, WRAPPED, TRIG_ADDR, LAST_ADDR);
      end
      drain("wrap");
      checks++;
      if (mem[7] !== 8'h27) begin errors++; $display("FAIL wrap_addr7: got %h, required 27", mem[7]); end
   endtask

   task automatic test_post_zero();
      arm();
      POST_CNT = 4'd0;
      smp(8'h30, 1'b0, 1, 4'd0);
      smp(8'h31, 1'b0, 1, 4'd1);
      smp(8'h32, 1'b1, 1, 4'd2);
      checks++;
      if ({DONE, BUSY, TRIGGERED, TRIG_ADDR, LAST_ADDR} !== {3'b101, 4'd2, 4'd2}) begin
         errors++;
         $display("FAIL post0_status: got done %b busy %b trig %b taddr %0d last %0d, required 1 0 1 2 2",
                  DONE, BUSY, TRIGGERED, TRIG_ADDR, LAST_ADDR);
      end
      smp(8'h33, 1'b0, 0, 4'd0);
      smp(8'h34, 1'b1, 0, 4'd0);
      drain("post0");
      checks++;
      if (DONE !== 1'b1) begin errors++; $display("FAIL post0_done_hold: got %b, required 1", DONE); end
   endtask

   task automatic test_gap();
      arm();
      TRIG = 1'b1;
      idle(1);
      TRIG = 1'b0;
      checks++;
      if (TRIGGERED !== 1'b0) begin errors++; $display("FAIL gap_trig_no_vld: got %b, required 0", TRIGGERED); end
      POST_CNT = 4'd3;
      smp(8'h40, 1'b0, 1, 4'd0);
      smp(8'h41, 1'b1, 1, 4'd1);
      for (int k = 0; k < 3; k++) begin
         idle(2);
         smp(8'h42 + 8'(k), 1'b1, 1, 4'(k + 2));
         if (k == 1) begin
            checks++;
            if ({BUSY, DONE} !== 2'b10) begin
               errors++;
               $display("FAIL gap_mid_post: got busy %b done %b, required 1 0", BUSY, DONE);
            end
         end
      end
      checks++;
      if ({DONE, TRIG_ADDR, LAST_ADDR} !== {1'b1, 4'd1, 4'd4}) begin
         errors++;
         $display("FAIL gap_status: got done %b trig %0d last %0d, required 1 1 4", DONE, TRIG_ADDR, LAST_ADDR);
      end
      drain("gap");
   endtask

   task automatic test_abort();
      arm();
      POST_CNT = 4'd4;
      smp(8'h50, 1'b0, 1, 4'd0);
      smp(8'h51, 1'b1, 1, 4'd1);
      smp(8'h52, 1'b0, 1, 4'd2);
      ABORT = 1'b1;
      smp(8'h53, 1'b0, 0, 4'd0);
      ABORT = 1'b0;
      checks++;
      if ({BUSY, DONE, TRIGGERED, TRIG_ADDR} !== {3'b000, 4'd1}) begin
         errors++;
         $display("FAIL abort_status: got busy %b done %b trig %b taddr %0d, required 0 0 0 1",
                  BUSY, DONE, TRIGGERED, TRIG_ADDR);
      end
      smp(8'h54, 1'b0, 0, 4'd0);
      ARM = 1'b1;
      ABORT = 1'b1;
      idle(1);
      ARM = 1'b0;
      ABORT = 1'b0;
      checks++;
      if (BUSY !== 1'b0) begin errors++; $display("FAIL abort_arm_same_cycle: got busy %b, required 0", BUSY); end
      smp(8'h55, 1'b0, 0, 4'd0);
      drain("abort");
   endtask

   task automatic test_rst_mid_post();
      arm();
      POST_CNT = 4'd5;
      smp(8'h60, 1'b1, 1, 4'd0);
      smp(8'h61, 1'b0, 1, 4'd1);
      smp(8'h62, 1'b0, 0, 4'd0);
      RST = 1'b1;
      #1;
      checks++;
      if ({RAM_DI, RAM_ADDR, RAM_WE, BUSY, TRIGGERED, DONE, WRAPPED, TRIG_ADDR, LAST_ADDR} !== 28'd0) begin
         errors++;
         $display("FAIL rst_async_outputs: got %h, required 0",
                  {RAM_DI, RAM_ADDR, RAM_WE, BUSY, TRIGGERED, DONE, WRAPPED, TRIG_ADDR, LAST_ADDR});
      end
      idle(1);
      RST = 1'b0;
      arm();
      smp(8'h70, 1'b0, 1, 4'd0);
      smp(8'h71, 1'b0, 1, 4'd1);
      drain("rst_rearm");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_wrap();
      test_post_zero();
      test_gap();
      test_abort();
      test_rst_mid_post();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
